// File: rtl/sevenseg_scan_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_pkg
// Shared constants for the seven-segment scan display block:
//   NUM_DIGITS  - digits on the display
//   SEG_BLANK   - active-low segment pattern with every segment off
//   HEX_SEG     - active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
// -----------------------------------------------------------------------------
package sevenseg_scan_pkg;

   localparam int         NUM_DIGITS = 4;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] HEX_SEG [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/sevenseg_scan_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_if
// Value-capture bus feeding the display.
//   value_in    - 16-bit value to display
//   value_valid - sample value_in this cycle
//   freeze      - ignore value_valid while high
// master: the producer (cpu board top / bench); slave: sevenseg_scan.
// -----------------------------------------------------------------------------
interface sevenseg_scan_if;
   logic [15:0] value_in;
   logic        value_valid;
   logic        freeze;

   modport master (output value_in, output value_valid, output freeze);
   modport slave  (input  value_in, input  value_valid, input  freeze);
endinterface

// File: rtl/sevenseg_scan_hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble - 4-bit hex digit
//   seg    - {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex_to_seg
   import sevenseg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// -----------------------------------------------------------------------------
// sevenseg_scan
// Captures a 16-bit value and scans it as four hex digits onto a common-anode
// 4-digit seven-segment display. A new value is latched into a shadow register
// and only moves into the displayed frame at a frame boundary, so one scan
// frame never mixes old and new digits.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   bus        - sevenseg_scan_if.slave (value_in, value_valid, freeze)
//   seg        - segments {g,f,e,d,c,b,a}, active-low
//   dp         - decimal point, active-low, always off
//   an         - digit enables, active-low, one-hot-low
//   frame_done - one-cycle pulse when digit 0 of a new frame lights
//
// Optional feature macro: SEVENSEG_LZB_EN (leading-zero blanking). When
// defined, a digit whose nibble and all higher nibbles are zero stays dark;
// digit 0 is always shown.
// -----------------------------------------------------------------------------
module sevenseg_scan
   import sevenseg_scan_pkg::*;
#(
   parameter  int SCAN_DIV = 100000,
   localparam int CNT_W    = $clog2(SCAN_DIV > 1 ? SCAN_DIV : 2)
) (
   input  logic                 clk,
   input  logic                 rst,
   sevenseg_scan_if.slave       bus,
   output logic [6:0]           seg,
   output logic                 dp,
   output logic [3:0]           an,
   output logic                 frame_done
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q,    cnt_d;
   digit_idx_t       idx_q,    idx_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [15:0]      frame_q,  frame_d;
   logic [3:0]       an_q,     an_d;
   logic [6:0]       seg_q,    seg_d;
   logic             frame_done_q, frame_done_d;

   logic       tick;
   logic       boundary;
   digit_idx_t nxt_idx;
   logic [3:0] nibble;
   logic [6:0] hex_seg;
   logic       lz_blank;

   hex_to_seg u_hex_to_seg (
      .nibble (nibble),
      .seg    (hex_seg)
   );

   always_comb begin
      tick     = (cnt_q == CNT_MAX);
      boundary = tick && (idx_q == 2'd3);
      nxt_idx  = idx_q + 2'd1;

      cnt_d        = tick ? '0 : cnt_q + 1'b1;
      idx_d        = tick ? nxt_idx : idx_q;
      shadow_d     = (bus.value_valid && !bus.freeze) ? bus.value_in : shadow_q;
      // At a boundary the old shadow moves into the frame; a value arriving on
      // the same edge waits in the shadow for the following frame.
      frame_d      = boundary ? shadow_q : frame_q;
      frame_done_d = boundary;

      // frame_d is the frame in effect for the digit being lit, which bypasses
      // the freshly loaded shadow at a boundary.
      nibble = frame_d[{nxt_idx, 2'b00} +: 4];

`ifdef SEVENSEG_LZB_EN
      lz_blank = (nxt_idx != 2'd0) && ((frame_d >> {nxt_idx, 2'b00}) == 16'd0);
`else
      lz_blank = 1'b0;
`endif

      an_d  = an_q;
      seg_d = seg_q;
      if (tick) begin
         an_d  = lz_blank ? 4'hF : ~(4'b0001 << nxt_idx);
         seg_d = lz_blank ? SEG_BLANK : hex_seg;
      end
   end

   // idx resets to 3 so the first tick is the 3->0 frame boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q        <= '0;
         idx_q        <= 2'd3;
         shadow_q     <= '0;
         frame_q      <= '0;
         an_q         <= 4'hF;
         seg_q        <= SEG_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         frame_q      <= frame_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;
   assign dp         = 1'b1;

endmodule
